// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA frame scheduler:
//   - Avalon register word offsets (CTRL, FB0, FB1, STATUS)
//   - CTRL and STATUS bit positions
//   - frame scheduler FSM state encoding
//   - alignBase(): clears the low five address bits, because the DRAM
//     reader bursts in 32-byte units and cannot start mid-burst
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_FB0    = 2'd1;
    localparam logic [1:0] REG_FB1    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_SWAP      = 1;
    localparam int CTRL_IRQ       = 2;

    localparam int STATUS_FRONT   = 0;
    localparam int STATUS_PENDING = 1;
    localparam int STATUS_FCNT_LO = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_LAUNCH  = 2'd2
    } state_t;

    function automatic logic [31:0] alignBase(input logic [31:0] addr);
        return {addr[31:5], 5'b0_0000};
    endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// ---------------------------------------------------------------------------
// vsync_edge_sync
// Brings an asynchronous sync signal into the clock domain with a two-flop
// synchroniser and produces a one-cycle pulse when it becomes active.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_sig    raw asynchronous input
//   o_edge   one-cycle pulse on the inactive-to-active transition
// Parameter POLARITY gives the active level (0 = active low, as VGA vsync).
// ---------------------------------------------------------------------------
module vsync_edge_sync #(
    parameter bit POLARITY = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Flops reset to the inactive level so leaving reset with the line
    // idle never looks like an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= ~POLARITY;
            r_sync <= ~POLARITY;
            r_prev <= ~POLARITY;
        end else begin
            r_meta <= i_sig;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Built only from flop outputs, so the pulse is glitch free.
    assign o_edge = (r_sync == POLARITY) && (r_prev != POLARITY);

endmodule

// File: rtl/vga_frame_scheduler.sv
// ---------------------------------------------------------------------------
// vga_frame_scheduler
// Starts the VGA DRAM reader once per frame and owns double buffering.
// On every vsync falling edge (while enabled) it applies any queued
// front/back swap, presents the front-buffer base on read_from_addr and
// pulses start for one cycle.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   vga_vsync_n                 VGA vsync, active low, asynchronous
//   gpu_swap_req                renderer pulse: back buffer finished
//   slave_address/read/write/
//   slave_writedata/readdata    Avalon-MM slave, read latency 1
//   start, read_from_addr       frame launch to the DRAM reader
//   back_buffer_addr            base the renderer draws into
//   swap_pending                a swap waits for the next vsync
//   irq                         sticky swap-done interrupt
// Registers: 0 CTRL, 1 FB0, 2 FB1, 3 STATUS.
// ---------------------------------------------------------------------------
module vga_frame_scheduler
    import vga_pkg::*;
#(
    parameter logic [31:0] FB0_RESET = 32'h0000_0000,
    parameter logic [31:0] FB1_RESET = 32'h0004_B000,
    parameter int          FCNT_W    = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        vga_vsync_n,
    input  logic        gpu_swap_req,
    input  logic [1:0]  slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic [31:0] slave_readdata,
    output logic        start,
    output logic [31:0] read_from_addr,
    output logic [31:0] back_buffer_addr,
    output logic        swap_pending,
    output logic        irq
);

    localparam logic [31:0] FB0_INIT = alignBase(FB0_RESET);
    localparam logic [31:0] FB1_INIT = alignBase(FB1_RESET);

    state_t r_state;
    state_t w_nextState;

    logic              r_enable;
    logic              r_front;
    logic              r_swapPending;
    logic              r_irq;
    logic              r_start;
    logic [31:0]       r_fb0;
    logic [31:0]       r_fb1;
    logic [31:0]       r_readFromAddr;
    logic [31:0]       r_readData;
    logic [FCNT_W-1:0] r_frameCnt;

    logic        w_vsEdge;
    logic        w_ctrlWrite;
    logic        w_launch;
    logic        w_doSwap;
    logic        w_newFront;
    logic [31:0] w_newBase;
    logic [31:0] w_readMux;

    vsync_edge_sync #(
        .POLARITY (1'b0)
    ) u_vsync (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_sig   (vga_vsync_n),
        .o_edge  (w_vsEdge)
    );

    assign w_ctrlWrite = slave_write && (slave_address == REG_CTRL);

    // The launch work is registered on the transition into LAUNCH, so start
    // and the new read_from_addr are both visible during the LAUNCH cycle,
    // one cycle after the vsync edge.
    assign w_launch   = (r_state == ST_WAIT_VS) && r_enable && w_vsEdge;
    assign w_doSwap   = w_launch && r_swapPending;
    assign w_newFront = r_front ^ w_doSwap;
    assign w_newBase  = w_newFront ? r_fb1 : r_fb0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Dropping enable from any state parks the FSM in IDLE, so no further
    // start is issued; the reader finishes its current frame on its own.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_enable) begin
                    w_nextState = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                if (!r_enable) begin
                    w_nextState = ST_IDLE;
                end else if (w_vsEdge) begin
                    w_nextState = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_nextState = r_enable ? ST_WAIT_VS : ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Frame launch: swap, latch the new front base, count the frame.
    // A zero base means "idle" to the reader, so start is withheld then.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_front        <= 1'b0;
            r_start        <= 1'b0;
            r_readFromAddr <= 32'h0000_0000;
            r_frameCnt     <= '0;
        end else begin
            r_start <= 1'b0;
            if (w_launch) begin
                r_front        <= w_newFront;
                r_readFromAddr <= w_newBase;
                r_start        <= (w_newBase != 32'h0000_0000);
                r_frameCnt     <= r_frameCnt + 1'b1;
            end
        end
    end

    // Any request sets pending; the set outranks the launch clear so a
    // request arriving in the launch cycle is kept for the next frame.
    // Likewise a launch swap outranks a simultaneous irq clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_swapPending <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            if (gpu_swap_req || (w_ctrlWrite && slave_writedata[CTRL_SWAP])) begin
                r_swapPending <= 1'b1;
            end else if (w_doSwap) begin
                r_swapPending <= 1'b0;
            end
            if (w_doSwap) begin
                r_irq <= 1'b1;
            end else if (w_ctrlWrite && slave_writedata[CTRL_IRQ]) begin
                r_irq <= 1'b0;
            end
        end
    end

    // Configuration writes; frame-buffer bases are kept burst aligned.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_enable <= 1'b0;
            r_fb0    <= FB0_INIT;
            r_fb1    <= FB1_INIT;
        end else if (slave_write) begin
            case (slave_address)
                REG_CTRL: r_enable <= slave_writedata[CTRL_ENABLE];
                REG_FB0:  r_fb0    <= alignBase(slave_writedata);
                REG_FB1:  r_fb1    <= alignBase(slave_writedata);
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_readMux = 32'h0000_0000;
        case (slave_address)
            REG_CTRL: begin
                w_readMux[CTRL_ENABLE] = r_enable;
                w_readMux[CTRL_SWAP]   = r_swapPending;
                w_readMux[CTRL_IRQ]    = r_irq;
            end
            REG_FB0: w_readMux = r_fb0;
            REG_FB1: w_readMux = r_fb1;
            REG_STATUS: begin
                w_readMux[STATUS_FRONT]                       = r_front;
                w_readMux[STATUS_PENDING]                     = r_swapPending;
                w_readMux[STATUS_FCNT_LO +: 16]               = 16'(r_frameCnt);
            end
            default: w_readMux = 32'h0000_0000;
        endcase
    end

    // Read data is sampled from current register values, so a read that
    // coincides with a write returns the value from before the write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_readData <= 32'h0000_0000;
        end else if (slave_read) begin
            r_readData <= w_readMux;
        end
    end

    assign slave_readdata   = r_readData;
    assign start            = r_start;
    assign read_from_addr   = r_readFromAddr;
    assign back_buffer_addr = r_front ? r_fb0 : r_fb1;
    assign swap_pending     = r_swapPending;
    assign irq              = r_irq;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_scheduler
// Directed bench for vga_frame_scheduler. FB0 is given a non-zero reset
// base so the very first frame actually issues a start pulse.
// ---------------------------------------------------------------------------
module tb_vga_frame_scheduler;
    import vga_pkg::*;

    localparam logic [31:0] FB0_INIT = 32'h0001_0000;
    localparam logic [31:0] FB1_INIT = 32'h0004_B000;

    logic        clk;
    logic        resetn;
    logic        vga_vsync_n;
    logic        gpu_swap_req;
    logic [1:0]  slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    logic        start;
    logic [31:0] read_from_addr;
    logic [31:0] back_buffer_addr;
    logic        swap_pending;
    logic        irq;

    int passCount  = 0;
    int checkCount = 0;

    vga_frame_scheduler #(
        .FB0_RESET (FB0_INIT),
        .FB1_RESET (FB1_INIT),
        .FCNT_W    (16)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .vga_vsync_n      (vga_vsync_n),
        .gpu_swap_req     (gpu_swap_req),
        .slave_address    (slave_address),
        .slave_read       (slave_read),
        .slave_write      (slave_write),
        .slave_writedata  (slave_writedata),
        .slave_readdata   (slave_readdata),
        .start            (start),
        .read_from_addr   (read_from_addr),
        .back_buffer_addr (back_buffer_addr),
        .swap_pending     (swap_pending),
        .irq              (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        slave_address   = addr;
        slave_writedata = data;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write     = 1'b0;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        slave_address = addr;
        slave_read    = 1'b1;
        @(negedge clk);
        slave_read    = 1'b0;
        data          = slave_readdata;
    endtask

    task automatic busReadWrite(input logic [1:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge clk);
        slave_address   = addr;
        slave_writedata = wdata;
        slave_read      = 1'b1;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        rdata           = slave_readdata;
    endtask

    task automatic gpuPulse();
        @(negedge clk);
        gpu_swap_req = 1'b1;
        @(negedge clk);
        gpu_swap_req = 1'b0;
    endtask

    // One frame: vsync low for 8 cycles then high for 4. Counts start
    // cycles and captures read_from_addr while start is high. reqAt > 0
    // raises gpu_swap_req across the posedge numbered reqAt after vsync
    // falls (posedge 3 is the launch edge).
    task automatic applyStimulus(input int reqAt, output int starts, output logic [31:0] addr);
        starts = 0;
        addr   = 32'h0;
        @(negedge clk);
        vga_vsync_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            gpu_swap_req = (i == reqAt);
            @(negedge clk);
            if (start) begin
                starts++;
                addr = read_from_addr;
            end
        end
        gpu_swap_req = 1'b0;
        vga_vsync_n  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        int          starts;
        logic        seen;

        resetn          = 1'b0;
        vga_vsync_n     = 1'b1;
        gpu_swap_req    = 1'b0;
        slave_address   = 2'd0;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_writedata = 32'h0;
        repeat (3) @(negedge clk);

        checkOutput("rst_start",    32'(start),        32'h0);
        checkOutput("rst_rdAddr",   read_from_addr,    32'h0);
        checkOutput("rst_irq",      32'(irq),          32'h0);
        checkOutput("rst_pending",  32'(swap_pending), 32'h0);
        checkOutput("rst_rdata",    slave_readdata,    32'h0);
        checkOutput("rst_back",     back_buffer_addr,  FB1_INIT);
        resetn = 1'b1;

        // First frame after enabling
        busWrite(REG_CTRL, 32'h1);
        busRead(REG_CTRL, rd);
        checkOutput("t1_ctrl", rd, 32'h1);
        applyStimulus(0, starts, addr);
        checkOutput("t1_starts", 32'(starts), 32'd1);
        checkOutput("t1_addr",   addr,        FB0_INIT);
        busRead(REG_STATUS, rd);
        checkOutput("t1_status", rd, 32'h0001_0000);

        // Aligned base write reaches the reader at the next frame
        busWrite(REG_FB0, 32'h1000_0013);
        busRead(REG_FB0, rd);
        checkOutput("t2_fb0", rd, 32'h1000_0000);
        checkOutput("t2_back", back_buffer_addr, FB1_INIT);
        applyStimulus(0, starts, addr);
        checkOutput("t2_starts", 32'(starts), 32'd1);
        checkOutput("t2_addr",   addr,        32'h1000_0000);

        // Renderer swap request applied at the next vsync
        gpuPulse();
        checkOutput("t3_pending", 32'(swap_pending), 32'h1);
        busRead(REG_CTRL, rd);
        checkOutput("t3_ctrl", rd, 32'h3);
        applyStimulus(0, starts, addr);
        checkOutput("t3_starts",  32'(starts),       32'd1);
        checkOutput("t3_addr",    addr,              FB1_INIT);
        checkOutput("t3_irq",     32'(irq),          32'h1);
        checkOutput("t3_pendClr", 32'(swap_pending), 32'h0);
        checkOutput("t3_back",    back_buffer_addr,  32'h1000_0000);
        busRead(REG_STATUS, rd);
        checkOutput("t3_status", rd, 32'h0003_0001);
        busWrite(REG_CTRL, 32'h5);
        checkOutput("t3_irqClr", 32'(irq), 32'h0);
        busRead(REG_CTRL, rd);
        checkOutput("t3_ctrl2", rd, 32'h1);

        // Three requests collapse into one swap; a request on the launch
        // edge survives and swaps again one frame later
        gpuPulse();
        busWrite(REG_CTRL, 32'h3);
        gpuPulse();
        checkOutput("t4_pending", 32'(swap_pending), 32'h1);
        applyStimulus(3, starts, addr);
        checkOutput("t4_starts",  32'(starts),       32'd1);
        checkOutput("t4_addr",    addr,              32'h1000_0000);
        checkOutput("t4_keep",    32'(swap_pending), 32'h1);
        checkOutput("t4_irq",     32'(irq),          32'h1);
        applyStimulus(0, starts, addr);
        checkOutput("t4_addr2",   addr,              FB1_INIT);
        checkOutput("t4_pendClr", 32'(swap_pending), 32'h0);

        // Read and write of the same register in one cycle
        busReadWrite(REG_FB0, 32'h2000_0000, rd);
        checkOutput("rw_old", rd, 32'h1000_0000);
        checkOutput("rw_back", back_buffer_addr, 32'h2000_0000);
        busRead(REG_FB0, rd);
        checkOutput("rw_new", rd, 32'h2000_0000);

        // Zero base suppresses start but the frame is still counted
        busWrite(REG_FB1, 32'h0);
        applyStimulus(0, starts, addr);
        checkOutput("t5_noStart", 32'(starts), 32'd0);
        busRead(REG_STATUS, rd);
        checkOutput("t5_status", rd, 32'h0006_0001);

        // Disabled scheduler ignores vsync
        busWrite(REG_FB1, 32'h0005_0000);
        busWrite(REG_CTRL, 32'h0);
        busRead(REG_CTRL, rd);
        checkOutput("t5_ctrl", rd, 32'h4);
        applyStimulus(0, starts, addr);
        checkOutput("t5_disStart", 32'(starts), 32'd0);
        busRead(REG_STATUS, rd);
        checkOutput("t5_status2", rd, 32'h0006_0001);

        // Reset dropped during the LAUNCH cycle
        busWrite(REG_CTRL, 32'h1);
        @(negedge clk);
        vga_vsync_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (start) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t6_launchSeen", 32'(seen), 32'h1);
        resetn = 1'b0;
        #1;
        checkOutput("t6_start",   32'(start),        32'h0);
        checkOutput("t6_rdAddr",  read_from_addr,    32'h0);
        checkOutput("t6_irq",     32'(irq),          32'h0);
        checkOutput("t6_pending", 32'(swap_pending), 32'h0);
        checkOutput("t6_back",    back_buffer_addr,  FB1_INIT);
        vga_vsync_n = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        busRead(REG_FB0, rd);
        checkOutput("t6_fb0", rd, FB0_INIT);
        busRead(REG_STATUS, rd);
        checkOutput("t6_status", rd, 32'h0);

        // Frame counter wrap
        busWrite(REG_CTRL, 32'h1);
        @(negedge clk);
        force dut.r_frameCnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frameCnt;
        busRead(REG_STATUS, rd);
        checkOutput("t6_preset", rd, 32'hFFFF_0000);
        applyStimulus(0, starts, addr);
        checkOutput("t6_wrapStart", 32'(starts), 32'd1);
        checkOutput("t6_wrapAddr",  addr,        FB0_INIT);
        busRead(REG_STATUS, rd);
        checkOutput("t6_wrap", rd, 32'h0000_0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
